// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

endpackage : seq_detect_pkg

// File: rtl/seq_detect_cmp.sv
// Combinational length-masked comparator: hit when the low len bits of
// history equal the low len bits of the pattern.
module seq_detect_cmp #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic [PAT_W-1:0] hist_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] mask_c;

  // Thermometer mask covering bit positions below len
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (LEN_W'(i) < len_i);
    end
  end

  assign hit_o = (((hist_i ^ pat_i) & mask_c) == '0);

endmodule : seq_detect_cmp

// File: rtl/seq_detect_n.sv
// Serial sequence detector with programmable pattern/length, overlapping or
// non-overlapping matching, sticky config error and optional match counter.
// Optional feature: define SEQDET_MATCH_CNT_EN to implement the saturating
// match counter; otherwise match_cnt is tied to zero.
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic [PAT_W-1:0]           pat,
  input  logic [$clog2(PAT_W+1)-1:0] pat_len,
  input  logic                       overlap,
  input  logic                       clr,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       err,
  output logic [1:0]                 state
);

  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic             en_q;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;

  logic [PAT_W-1:0] shift_c;
  logic [LEN_W-1:0] fill_inc_c;
  logic             len_legal_c;
  logic             hit_c;

  // History with the current bit appended, and fill saturating at length
  assign shift_c     = {hist_q[PAT_W-2:0], in};
  assign fill_inc_c  = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
  assign len_legal_c = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));

  seq_detect_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist_i (shift_c),
    .pat_i  (pat_q),
    .len_i  (len_q),
    .hit_o  (hit_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      err_q   <= err_d;
      en_q    <= en;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
    end
  end

  // Next-state, config latch, shift/fill and match decision
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    err_d   = err_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;

    if (!en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Config is captured only on the enable rising edge
          if (!en_q) begin
            pat_d  = pat;
            len_d  = pat_len;
            ovl_d  = overlap;
            hist_d = '0;
            fill_d = '0;
            if (len_legal_c) begin
              state_d = FILL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        FILL, ARMED: begin
          if (in_valid && !clr) begin
            hist_d = shift_c;
            fill_d = fill_inc_c;
            if (hit_c && (fill_inc_c == len_q)) begin
              match_d = 1'b1;
              if (ovl_q) begin
                state_d = ARMED;
              end else begin
                fill_d  = '0;
                state_d = FILL;
              end
            end else if (fill_inc_c == len_q) begin
              state_d = ARMED;
            end else begin
              state_d = FILL;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Clear wins over everything except the enable drop
    if (clr) begin
      hist_d  = '0;
      fill_d  = '0;
      err_d   = 1'b0;
      match_d = 1'b0;
      if (en && (state_q != IDLE)) begin
        state_d = FILL;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

  assign match = match_q;
  assign err   = err_q;
  assign state = state_q;

endmodule : seq_detect_n

// File: tb/tb_seq_detect_n.sv
// Self-checking bench for seq_detect_n: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_seq_detect_n;

  localparam int unsigned PAT_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT2_W = 2;
`ifdef SEQDET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              in = 1'b0;
  logic              in_valid = 1'b0;
  logic              overlap = 1'b0;
  logic              clr = 1'b0;
  logic [PAT_W-1:0]  pat = '0;
  logic [3:0]        pat_len = '0;

  logic              match, match2, err, err2;
  logic [CNT_W-1:0]  cnt;
  logic [CNT2_W-1:0] cnt2;
  logic [1:0]        state, state2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit         m_active, m_prev_en, m_ovl, m_err, m_match;
  bit [7:0]   m_pat;
  int         m_len, m_cnt;
  bit         q[$];

  always #5 clk = ~clk;

  seq_detect_n #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .match(match), .match_cnt(cnt), .err(err), .state(state)
  );

  seq_detect_n #(.PAT_W(PAT_W), .CNT_W(CNT2_W)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .clr(clr),
    .match(match2), .match_cnt(cnt2), .err(err2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pat_ok();
    for (int k = 0; k < m_len; k++) begin
      if (q[q.size()-1-k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_prev_en = 0; m_ovl = 0; m_err = 0; m_match = 0;
    m_pat = '0; m_len = 0; m_cnt = 0;
    q.delete();
  endtask

  // One clock of the behavioural model, using the inputs sampled at the edge
  task automatic model_step();
    m_match = 0;
    if (!en) begin
      m_active = 0;
      q.delete();
    end else if (!m_active && !m_prev_en) begin
      m_pat = pat; m_len = int'(pat_len); m_ovl = overlap;
      q.delete();
      if (m_len >= 1 && m_len <= int'(PAT_W)) m_active = 1;
      else m_err = 1;
    end else if (m_active && in_valid && !clr) begin
      q.push_back(in);
      while (q.size() > m_len) void'(q.pop_front());
      if (q.size() == m_len && pat_ok()) begin
        m_match = 1;
        m_cnt++;
        if (!m_ovl) q.delete();
      end
    end
    if (clr) begin
      q.delete();
      m_cnt = 0;
      m_err = 0;
    end
    m_prev_en = en;
  endtask

  function automatic int exp_state();
    if (!m_active) return 0;
    return (q.size() >= m_len) ? 2 : 1;
  endfunction

  function automatic int sat(input int v, input int maxv);
    if (!CNT_ON) return 0;
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".match"},  match,  m_match);
    chk({tag, ".err"},    err,    m_err);
    chk({tag, ".state"},  state,  exp_state());
    chk({tag, ".cnt"},    cnt,    sat(m_cnt, 65535));
    chk({tag, ".match2"}, match2, m_match);
    chk({tag, ".err2"},   err2,   m_err);
    chk({tag, ".state2"}, state2, exp_state());
    chk({tag, ".cnt2"},   cnt2,   sat(m_cnt, 3));
  endtask

  task automatic cyc(input logic e, input logic v, input logic b, input logic c,
                     input string tag);
    en = e; in_valid = v; in = b; clr = c;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    pat = p; pat_len = l; overlap = o;
  endtask

  logic [7:0] p8;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Overlapping 111 over five ones
    cyc(0, 0, 0, 1, "clr036");
    cfg(8'b111, 4'd3, 1'b1);
    cyc(1, 0, 0, 0, "latch036");
    chk("req036.fill_state", state, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 1, 0, "req036");
      if (k >= 3) chk("req036.match", match, 1);
    end
    chk("req036.cnt", cnt, CNT_ON ? 3 : 0);
    cyc(0, 0, 0, 0, "off036");

    // Non-overlapping 111 over five ones
    cyc(0, 0, 0, 1, "clr037");
    cfg(8'b111, 4'd3, 1'b0);
    cyc(1, 0, 0, 0, "latch037");
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 1, 1, 0, "req037");
      chk("req037.match", match, (k == 3) ? 1 : 0);
      if (k == 3) chk("req037.state", state, 1);
    end
    chk("req037.cnt", cnt, CNT_ON ? 1 : 0);
    cyc(0, 0, 0, 0, "off037");

    // Eight-bit pattern with one idle cycle between valid bits
    cyc(0, 0, 0, 1, "clr038");
    p8 = 8'b10110110;
    cfg(p8, 4'd8, 1'b0);
    cyc(1, 0, 0, 0, "latch038");
    for (int i = 7; i >= 0; i--) begin
      cyc(1, 1, p8[i], 0, "req038");
      chk("req038.match", match, (i == 0) ? 1 : 0);
      cyc(1, 0, 1'($urandom), 0, "req038gap");
      chk("req038.gap", match, 0);
    end
    cyc(0, 0, 0, 0, "off038");

    // Illegal zero length
    cfg(8'h5A, 4'd0, 1'b1);
    cyc(1, 0, 0, 0, "latch039");
    chk("req039.err", err, 1);
    chk("req039.state", state, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 1'($urandom), 0, "req039");
    end
    cyc(0, 0, 0, 1, "clr039");
    chk("req039.err_clr", err, 0);

    // Clear on the completing bit, then counter saturation
    cfg(8'b101, 4'd3, 1'b1);
    cyc(1, 0, 0, 0, "latch040");
    cyc(1, 1, 1, 0, "req040a");
    cyc(1, 1, 0, 0, "req040b");
    cyc(1, 1, 1, 1, "req040clr");
    chk("req040.clr_match", match, 0);
    chk("req040.clr_cnt", cnt, 0);
    for (int k = 0; k < 11; k++) begin
      cyc(1, 1, (k % 2 == 0) ? 1'b1 : 1'b0, 0, "req040run");
    end
    chk("req040.cnt16", cnt, CNT_ON ? 5 : 0);
    chk("req040.cnt2", cnt2, CNT_ON ? 3 : 0);
    cyc(0, 0, 0, 0, "off040");

    // Asynchronous reset mid-pattern
    cyc(0, 0, 0, 1, "clr041");
    cfg(8'b111, 4'd3, 1'b1);
    cyc(1, 0, 0, 0, "latch041");
    cyc(1, 1, 1, 0, "req041a");
    cyc(1, 1, 1, 0, "req041b");
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("req041.async");
    chk("req041.state", state, 0);
    @(posedge clk);
    #1;
    check_all("req041.held");
    @(negedge clk);
    rst = 1'b1;
    cyc(1, 1, 1, 0, "req041latch");
    cyc(1, 1, 1, 0, "req041c");
    chk("req041.nomatch", match, 0);
    cyc(1, 1, 1, 0, "req041d");
    chk("req041.nomatch2", match, 0);
    cyc(1, 1, 1, 0, "req041e");
    chk("req041.match", match, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom));
      end
      cyc(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 39) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_seq_detect_n
